// File: rtl/md_unit.sv
// Multiply/divide unit: HI/LO registers plus a multi-cycle mult/div sequencer.
// The result is computed at issue and held in pending registers. HI/LO are
// updated only when the busy countdown expires, so reads during a run return
// the previously committed values.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Operation encodings on md_op; NONE and reserved fall through to no-op
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    p_hi_q, p_hi_d;
  logic [DW-1:0]    p_lo_q, p_lo_d;
  logic [DW-1:0]    hi_q, hi_d;
  logic [DW-1:0]    lo_q, lo_d;

  // Arithmetic results for the current operands
  logic signed [PW-1:0] a_sx, b_sx, prod_s;
  logic [PW-1:0]        prod_u;
  logic                 a_neg, b_neg, b_zero;
  logic [DW-1:0]        a_mag, b_mag;
  logic [DW-1:0]        sq_mag, sr_mag;
  logic [DW-1:0]        div_q, div_r;
  logic [DW-1:0]        divu_q, divu_r;

  // Products and quotients; signed divide works on magnitudes so that
  // 0x80000000 / -1 needs no special case (magnitude 2^31 fits unsigned).
  always_comb begin
    a_sx   = {{DW{a[DW-1]}}, a};
    b_sx   = {{DW{b[DW-1]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    b_zero = (b == '0);
    a_neg  = a[DW-1];
    b_neg  = b[DW-1];
    a_mag  = a_neg ? (~a + DW'(1)) : a;
    b_mag  = b_neg ? (~b + DW'(1)) : b;

    sq_mag = '0;
    sr_mag = '0;
    divu_q = '0;
    divu_r = '0;
    if (!b_zero) begin
      sq_mag = a_mag / b_mag;
      sr_mag = a_mag % b_mag;
      divu_q = a / b;
      divu_r = a % b;
    end
    div_q = (a_neg ^ b_neg) ? (~sq_mag + DW'(1)) : sq_mag;
    div_r = a_neg ? (~sr_mag + DW'(1)) : sr_mag;
  end

  // Next-state: issue in IDLE, countdown and commit in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              p_hi_d  = prod_s[PW-1:DW];
              p_lo_d  = prod_s[DW-1:0];
              cnt_d   = MULT_CNT;
              state_d = ST_RUN;
            end
            OP_MULTU: begin
              p_hi_d  = prod_u[PW-1:DW];
              p_lo_d  = prod_u[DW-1:0];
              cnt_d   = MULT_CNT;
              state_d = ST_RUN;
            end
            OP_DIV: begin
              // Divide by zero recommits the current HI/LO unchanged
              p_hi_d  = b_zero ? hi_q : div_r;
              p_lo_d  = b_zero ? lo_q : div_q;
              cnt_d   = DIV_CNT;
              state_d = ST_RUN;
            end
            OP_DIVU: begin
              p_hi_d  = b_zero ? hi_q : divu_r;
              p_lo_d  = b_zero ? lo_q : divu_q;
              cnt_d   = DIV_CNT;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // Starts are ignored here; only the countdown advances
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update; reset wins over any issue or commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign hi     = hi_q;
  assign lo     = lo_q;
  // Read port for mfhi/mflo; committed values only
  assign md_out = rd_hi ? hi_q : lo_q;

endmodule
